// File: rtl/motor_pwm_pkg.sv
// Shared types and command-word layout for the motor PWM drive.
package motor_pwm_pkg;

  localparam int unsigned CMD_W        = 16;
  localparam int unsigned CMD_DIR_BIT  = 15;
  localparam int unsigned CMD_EN_BIT   = 14;
  localparam int unsigned PWM_BITS_MAX = 14;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    DEADTIME = 2'd2
  } state_e;

endpackage

// File: rtl/motor_pwm_counter.sv
// Prescaler plus PWM period counter; counts 0..2^PWM_BITS-2 and flags each wrap to 0.
module motor_pwm_counter #(
  parameter int unsigned PWM_BITS = 12,
  parameter int unsigned CLK_DIV  = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic [PWM_BITS-1:0] cnt,
  output logic                period_tick
);

  localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((1 << PWM_BITS) - 2);

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic                tick_q, tick_d;
  logic                advance;

  // Next prescaler/counter values; tick marks the cycle the counter becomes 0.
  always_comb begin
    advance = (presc_q == PRE_LAST);
    presc_d = advance ? '0 : presc_q + PRE_W'(1);
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    if (advance) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + PWM_BITS'(1);
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
    end
  end

  assign cnt         = cnt_q;
  assign period_tick = tick_q;

endmodule

// File: rtl/motor_pwm_drive.sv
// H-bridge PWM driver fed by the motor PIO command word.
// Period-boundary duty/direction updates, dead-time on reversal.
// Optional duty ramping when MOTOR_PWM_RAMP_EN is defined.
module motor_pwm_drive
  import motor_pwm_pkg::*;
#(
  parameter int unsigned PWM_BITS     = 12,
  parameter int unsigned CLK_DIV      = 1,
  parameter int unsigned DEADTIME_CYC = 64,
  parameter int unsigned RAMP_STEP    = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CMD_W-1:0]    cmd,
  output logic                pwm_a,
  output logic                pwm_b,
  output logic                active,
  output logic                deadtime_busy,
  output logic                dir_applied,
  output logic [PWM_BITS-1:0] duty_applied,
  output logic                period_tick
);

  if (PWM_BITS > PWM_BITS_MAX || PWM_BITS < 2) begin : g_bad_pwm_bits
    $error("motor_pwm_drive: PWM_BITS must be in 2..14");
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("motor_pwm_drive: CLK_DIV must be >= 1");
  end
  if (DEADTIME_CYC < 1) begin : g_bad_deadtime
    $error("motor_pwm_drive: DEADTIME_CYC must be >= 1");
  end
  if (RAMP_STEP < 1) begin : g_bad_ramp_step
    $error("motor_pwm_drive: RAMP_STEP must be >= 1");
  end

  localparam int unsigned DT_W = (DEADTIME_CYC > 1) ? $clog2(DEADTIME_CYC) : 1;
  localparam logic [DT_W-1:0] DT_LAST = DT_W'(DEADTIME_CYC - 1);

  logic [CMD_W-1:0]    cmd_q;
  state_e              state_q, state_d;
  logic [DT_W-1:0]     dt_cnt_q, dt_cnt_d;
  logic                dir_q, dir_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                pwm_a_q, pwm_a_d;
  logic                pwm_b_q, pwm_b_d;

  logic [PWM_BITS-1:0] cnt;
  logic                cmd_en, cmd_dir;
  logic [PWM_BITS-1:0] cmd_duty;
  logic [PWM_BITS-1:0] run_duty, entry_duty;
  logic                pwm_on;
  logic                unused_cmd;

  motor_pwm_counter #(
    .PWM_BITS (PWM_BITS),
    .CLK_DIV  (CLK_DIV)
  ) u_counter (
    .clk         (clk),
    .reset_n     (reset_n),
    .cnt         (cnt),
    .period_tick (period_tick)
  );

  assign cmd_en     = cmd_q[CMD_EN_BIT];
  assign cmd_dir    = cmd_q[CMD_DIR_BIT];
  assign cmd_duty   = cmd_q[PWM_BITS-1:0];
  assign unused_cmd = ^cmd_q;

`ifdef MOTOR_PWM_RAMP_EN
  localparam logic [PWM_BITS:0] RAMP_STEP_W = (PWM_BITS+1)'(RAMP_STEP);

  function automatic logic [PWM_BITS-1:0] ramp_toward(input logic [PWM_BITS-1:0] cur,
                                                       input logic [PWM_BITS-1:0] tgt);
    logic [PWM_BITS-1:0] diff;
    logic [PWM_BITS-1:0] step;
    diff = (tgt >= cur) ? (tgt - cur) : (cur - tgt);
    step = ({1'b0, diff} > RAMP_STEP_W) ? RAMP_STEP_W[PWM_BITS-1:0] : diff;
    return (tgt >= cur) ? (cur + step) : (cur - step);
  endfunction

  // Duty candidates: one bounded step per period, entry ramps up from zero.
  always_comb begin
    run_duty   = ramp_toward(duty_q, cmd_duty);
    entry_duty = ramp_toward('0, cmd_duty);
  end
`else
  // Duty candidates: step straight to the commanded duty.
  always_comb begin
    run_duty   = cmd_duty;
    entry_duty = cmd_duty;
  end
`endif

  // Next-state, applied direction/duty and bridge drive.
  always_comb begin
    state_d  = state_q;
    dt_cnt_d = dt_cnt_q;
    dir_d    = dir_q;
    duty_d   = duty_q;
    unique case (state_q)
      IDLE: begin
        duty_d = '0;
        if (period_tick && cmd_en) begin
          state_d = RUN;
          dir_d   = cmd_dir;
          duty_d  = entry_duty;
        end
      end
      RUN: begin
        if (!cmd_en) begin
          state_d = IDLE;
          duty_d  = '0;
        end else if (period_tick) begin
          if (cmd_dir != dir_q) begin
            state_d  = DEADTIME;
            dt_cnt_d = '0;
            duty_d   = '0;
          end else begin
            duty_d = run_duty;
          end
        end
      end
      DEADTIME: begin
        duty_d = '0;
        if (!cmd_en) begin
          state_d = IDLE;
        end else if (dt_cnt_q == DT_LAST) begin
          state_d  = RUN;
          dir_d    = cmd_dir;
          dt_cnt_d = '0;
        end else begin
          dt_cnt_d = dt_cnt_q + DT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        duty_d  = '0;
      end
    endcase
    pwm_on  = (state_d == RUN) && (cnt < duty_d);
    pwm_a_d = pwm_on & ~dir_d;
    pwm_b_d = pwm_on & dir_d;
  end

  // Command capture, FSM and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q    <= '0;
      state_q  <= IDLE;
      dt_cnt_q <= '0;
      dir_q    <= 1'b0;
      duty_q   <= '0;
      pwm_a_q  <= 1'b0;
      pwm_b_q  <= 1'b0;
    end else begin
      cmd_q    <= cmd;
      state_q  <= state_d;
      dt_cnt_q <= dt_cnt_d;
      dir_q    <= dir_d;
      duty_q   <= duty_d;
      pwm_a_q  <= pwm_a_d;
      pwm_b_q  <= pwm_b_d;
    end
  end

  assign pwm_a         = pwm_a_q;
  assign pwm_b         = pwm_b_q;
  assign active        = (state_q == RUN);
  assign deadtime_busy = (state_q == DEADTIME);
  assign dir_applied   = dir_q;
  assign duty_applied  = duty_q;

endmodule

// File: tb/tb_motor_pwm_drive.sv
// Directed bench for motor_pwm_drive at PWM_BITS=8 (255-count period), CLK_DIV=1, 64-cycle dead-time.
module tb_motor_pwm_drive;

  localparam int unsigned PWM_BITS     = 8;
  localparam int unsigned CLK_DIV      = 1;
  localparam int unsigned DEADTIME_CYC = 64;
  localparam int unsigned RAMP_STEP    = 16;
  localparam int          PERIOD       = 255;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [15:0]         cmd;
  logic                pwm_a, pwm_b, active, deadtime_busy, dir_applied, period_tick;
  logic [PWM_BITS-1:0] duty_applied;

  int tests_run    = 0;
  int tests_failed = 0;

  motor_pwm_drive #(
    .PWM_BITS     (PWM_BITS),
    .CLK_DIV      (CLK_DIV),
    .DEADTIME_CYC (DEADTIME_CYC),
    .RAMP_STEP    (RAMP_STEP)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd           (cmd),
    .pwm_a         (pwm_a),
    .pwm_b         (pwm_b),
    .active        (active),
    .deadtime_busy (deadtime_busy),
    .dir_applied   (dir_applied),
    .duty_applied  (duty_applied),
    .period_tick   (period_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the next negedge at which period_tick is high.
  task automatic wait_tick(input string tag);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 600) begin
      @(negedge clk);
      n++;
      if (period_tick) seen = 1'b1;
    end
    if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Count high cycles over one full PWM period.
  task automatic window(output int na, output int nb, output int nbusy, output int nboth);
    na = 0; nb = 0; nbusy = 0; nboth = 0;
    repeat (PERIOD) begin
      @(negedge clk);
      na    += int'(pwm_a);
      nb    += int'(pwm_b);
      nbusy += int'(deadtime_busy);
      nboth += int'(pwm_a & pwm_b);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, nz, na, nb, nbusy, nboth;
    bit seen;

    // Reset held with an enabled command present.
    reset_n = 1'b1;
    cmd     = 16'hC0FF;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_pwm_a", 32'(pwm_a), 32'd0);
    chk("rst_pwm_b", 32'(pwm_b), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_duty", 32'(duty_applied), 32'd0);
    nz = 0;
    repeat (4) begin
      @(negedge clk);
      nz += int'(pwm_a | pwm_b | active | (duty_applied != '0) | period_tick);
    end
    chk("rst_held_quiet", 32'(nz), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Outputs stay quiet until the first wrap.
    n = 0; nz = 0; seen = 1'b0;
    while (!seen && n < 600) begin
      @(negedge clk);
      n++;
      nz += int'(pwm_a | pwm_b | active | (duty_applied != '0));
      if (period_tick) seen = 1'b1;
    end
    chk("pre_tick_quiet", 32'(nz), 32'd0);
    chk("first_tick_latency", 32'(n), 32'd255);
    @(negedge clk);
    chk("t1_active", 32'(active), 32'd1);
    chk("t1_dir", 32'(dir_applied), 32'd1);
`ifdef MOTOR_PWM_RAMP_EN
    chk("t1_duty", 32'(duty_applied), 32'd16);
`else
    chk("t1_duty", 32'(duty_applied), 32'd255);
`endif
    chk("t1_pwm_b", 32'(pwm_b), 32'd1);
    chk("t1_pwm_a", 32'(pwm_a), 32'd0);
    cmd = 16'h0000;
    repeat (3) @(negedge clk);
    chk("t1_off_active", 32'(active), 32'd0);
    chk("t1_off_pwm_b", 32'(pwm_b), 32'd0);

`ifdef MOTOR_PWM_RAMP_EN
    // Ramp up 16 per period from zero, then a single step down.
    cmd = 16'h4080;
    for (int k = 1; k <= 8; k++) begin
      wait_tick("t6_tick");
      @(negedge clk);
      chk($sformatf("t6_ramp_%0d", k), 32'(duty_applied), 32'(16 * k));
    end
    cmd = 16'h4070;
    wait_tick("t6_down_tick");
    @(negedge clk);
    chk("t6_down", 32'(duty_applied), 32'd112);
    window(na, nb, nbusy, nboth);
    chk("t6_pwm_a_count", 32'(na), 32'd112);
    chk("t6_pwm_b_count", 32'(nb), 32'd0);
    wait_tick("t6_hold_tick");
    @(negedge clk);
    chk("t6_hold", 32'(duty_applied), 32'd112);
`else
    // Forward 50 % duty.
    cmd = 16'h4080;
    wait_tick("t2_tick");
    window(na, nb, nbusy, nboth);
    chk("t2_pwm_a_count", 32'(na), 32'd128);
    chk("t2_pwm_b_count", 32'(nb), 32'd0);
    chk("t2_duty", 32'(duty_applied), 32'd128);
    chk("t2_dir", 32'(dir_applied), 32'd0);
    chk("t2_active", 32'(active), 32'd1);

    // Reversal: 64-cycle dead-time, then reverse PWM from the following tick.
    repeat (20) @(negedge clk);
    cmd = 16'hC080;
    wait_tick("t3_tick");
    window(na, nb, nbusy, nboth);
    chk("t3_dt_busy", 32'(nbusy), 32'd64);
    chk("t3_dt_pwm_a", 32'(na), 32'd0);
    chk("t3_dt_pwm_b", 32'(nb), 32'd0);
    window(na, nb, nbusy, nboth);
    chk("t3_pwm_b_count", 32'(nb), 32'd128);
    chk("t3_pwm_a_count", 32'(na), 32'd0);
    chk("t3_busy_after", 32'(nbusy), 32'd0);
    chk("t3_dir", 32'(dir_applied), 32'd1);

    // Direction toggled back during dead-time: full length, direction sampled at exit.
    repeat (20) @(negedge clk);
    cmd = 16'h4080;
    wait_tick("t3b_tick");
    nbusy = 0;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      if (i == 10) cmd = 16'hC080;
      if (i == 30) cmd = 16'h4080;
      nbusy += int'(deadtime_busy);
    end
    chk("t3b_dt_busy", 32'(nbusy), 32'd64);
    chk("t3b_dir", 32'(dir_applied), 32'd0);
    window(na, nb, nbusy, nboth);
    chk("t3b_pwm_a_count", 32'(na), 32'd128);

    // Duty 0: forward, output constantly low.
    cmd = 16'h4000;
    wait_tick("t5_zero_tick");
    window(na, nb, nbusy, nboth);
    chk("t5_zero_pwm_a", 32'(na), 32'd0);
    chk("t5_zero_pwm_b", 32'(nb), 32'd0);
    chk("t5_zero_active", 32'(active), 32'd1);

    // Duty all-ones: constantly high across the wrap.
    cmd = 16'h40FF;
    wait_tick("t5_full_tick");
    window(na, nb, nbusy, nboth);
    chk("t5_full_pwm_a", 32'(na), 32'd255);
    chk("t5_full_pwm_b", 32'(nb), 32'd0);
    chk("t5_never_both", 32'(nboth), 32'd0);

    // Enable drop mid-period: low two cycles after the command changes.
    repeat (50) @(negedge clk);
    cmd = 16'h0000;
    @(negedge clk);
    chk("t4_still_high", 32'(pwm_a), 32'd1);
    @(negedge clk);
    chk("t4_pwm_a_low", 32'(pwm_a), 32'd0);
    chk("t4_active", 32'(active), 32'd0);
    chk("t4_duty", 32'(duty_applied), 32'd0);

    // Re-enable waits for the period boundary.
    cmd = 16'h4080;
    repeat (3) @(negedge clk);
    chk("t4_reenable_gated", 32'(active), 32'd0);
    wait_tick("t4_reenable_tick");
    @(negedge clk);
    chk("t4_reenable_active", 32'(active), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
